uart_apb_arbiter: RTL and testbench

- Two-requester APB master that shares the single APB port of the UART register block (UART_Register_Top) between requester 0 (CPU) and requester 1 (DMA/TX feeder).
- Accepts transfer requests over valid/ready and arbitrates them round-robin or by fixed priority.
- Drives legal APB setup/access phases (pSel, pEnable, pWrite, pAddr, pWdata) and returns read data and completion to the winning requester.
- Sits between the requesters and UART_Register_Top.

---
 rtl/uart_apb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_apb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_arbiter
// Purpose  : Two-requester APB master sharing the UART register block's single
//            APB port between requester 0 (CPU) and requester 1 (DMA/TX feeder).
//            Requests arrive over valid/ready and are arbitrated round-robin
//            (RR_EN=1) or with requester 0 at fixed priority (RR_EN=0). Each
//            grant runs one APB SETUP + ACCESS pair; completion is reported as
//            a one-cycle rvalid pulse to the winner, with read data.
// Ports    : pClk, pReset (async, active low)
//            reqN_valid/write/addr/wdata  -> request from requester N
//            reqN_ready                   <- request accepted this cycle
//            reqN_rvalid/rdata            <- completion pulse and read data
//            pSel/pEnable/pWrite/pAddr/pWdata -> APB master outputs
//            pReadData                    <- APB read data
//            pReady (UART_APB_PREADY_EN only) <- APB wait-state input
// Options  : `define UART_APB_PREADY_EN adds pReady; ACCESS then stretches
//            until pReady=1. Without it ACCESS is always one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              pSel,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWdata,
    input  logic [DATA_W-1:0] pReadData
`ifdef UART_APB_PREADY_EN
    ,
    input  logic              pReady
`endif
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic              w_pReady;
    logic              w_accessDone;
    logic              w_grant;
    logic              w_winner;     // 0 = requester 0, 1 = requester 1
    logic              r_lastGrant;
    logic              r_owner;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

`ifdef UART_APB_PREADY_EN
    assign w_pReady = pReady;
`else
    assign w_pReady = 1'b1;
`endif

    assign w_accessDone = (r_state == c_ST_ACCESS) && w_pReady;

    generate
        if (RR_EN != 0) begin : g_roundRobin
            // On a tie the requester that did not win last time goes next.
            assign w_winner = (req0_valid && req1_valid) ? ~r_lastGrant : req1_valid;
        end else begin : g_fixedPriority
            assign w_winner = ~req0_valid;
        end
    endgenerate

    // Grant only at an arbitration point; gating with pReset keeps ready low
    // while reset is held even though ready is combinational.
    assign w_grant = pReset && (req0_valid || req1_valid) &&
                     ((r_state == c_ST_IDLE) || w_accessDone);

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) r_state <= c_ST_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        pSel        = 1'b0;
        pEnable     = 1'b0;
        req0_ready  = w_grant && !w_winner;
        req1_ready  = w_grant &&  w_winner;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) w_nextState = c_ST_SETUP;
            end
            c_ST_SETUP: begin
                pSel        = 1'b1;
                w_nextState = c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
                pSel    = 1'b1;
                pEnable = 1'b1;
                if (w_pReady) w_nextState = w_grant ? c_ST_SETUP : c_ST_IDLE;
            end
            default: w_nextState = c_ST_IDLE;
        endcase
    end

    // Request capture and completion. Completion uses the owner of the
    // finishing transfer, which may differ from a grant made on the same edge.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_lastGrant <= 1'b1;
            r_owner     <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_rvalid0 <= w_accessDone && !r_owner;
            r_rvalid1 <= w_accessDone &&  r_owner;
            if (w_accessDone && !r_owner) r_rdata0 <= r_write ? '0 : pReadData;
            if (w_accessDone &&  r_owner) r_rdata1 <= r_write ? '0 : pReadData;
            if (w_grant) begin
                r_lastGrant <= w_winner;
                r_owner     <= w_winner;
                r_write     <= w_winner ? req1_write : req0_write;
                r_addr      <= w_winner ? req1_addr  : req0_addr;
                r_wdata     <= w_winner ? req1_wdata : req0_wdata;
            end
        end
    end

    assign pWrite      = r_write;
    assign pAddr       = r_addr;
    assign pWdata      = r_wdata;
    assign req0_rvalid = r_rvalid0;
    assign req1_rvalid = r_rvalid1;
    assign req0_rdata  = r_rdata0;
    assign req1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_arbiter
// Purpose  : Self-checking bench for uart_apb_arbiter. Two instances run on the
//            same stimulus: index 0 is round-robin, index 1 fixed priority.
//            A transaction-level model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb_arbiter;

    logic        pClk = 1'b0;
    logic        pReset = 1'b0;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic [31:0] pReadData = '0;
`ifdef UART_APB_PREADY_EN
    logic        pReady = 1'b1;
`endif

    logic [1:0]  req0Ready, req1Ready, req0Rvalid, req1Rvalid, pSel, pEnable, pWrite;
    logic [31:0] req0Rdata [2];
    logic [31:0] req1Rdata [2];
    logic [31:0] pAddr [2];
    logic [31:0] pWdata [2];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always #5 pClk = ~pClk;

    uart_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) u_rr (
        .pClk(pClk), .pReset(pReset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0Ready[0]), .req0_rvalid(req0Rvalid[0]),
        .req0_rdata(req0Rdata[0]),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1Ready[0]), .req1_rvalid(req1Rvalid[0]),
        .req1_rdata(req1Rdata[0]),
        .pSel(pSel[0]), .pEnable(pEnable[0]), .pWrite(pWrite[0]), .pAddr(pAddr[0]),
        .pWdata(pWdata[0]), .pReadData(pReadData)
`ifdef UART_APB_PREADY_EN
        , .pReady(pReady)
`endif
    );

    uart_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) u_fp (
        .pClk(pClk), .pReset(pReset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0Ready[1]), .req0_rvalid(req0Rvalid[1]),
        .req0_rdata(req0Rdata[1]),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1Ready[1]), .req1_rvalid(req1Rvalid[1]),
        .req1_rdata(req1Rdata[1]),
        .pSel(pSel[1]), .pEnable(pEnable[1]), .pWrite(pWrite[1]), .pAddr(pAddr[1]),
        .pWdata(pWdata[1]), .pReadData(pReadData)
`ifdef UART_APB_PREADY_EN
        , .pReady(pReady)
`endif
    );

    // ---------------- transaction-level reference model ----------------
    // A granted transfer at cycle g shows SETUP at g+1, ACCESS at g+2 (which is
    // also the next arbitration point) and its completion pulse at g+3.
    bit          mBusy [2];
    int          mGrantCyc [2];
    bit          mOwner [2], mWr [2], mLast [2], mRv0 [2], mRv1 [2];
    logic [31:0] mAddr [2], mWdata [2], mRd0 [2], mRd1 [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mBusy[d] = 0; mGrantCyc[d] = 0; mOwner[d] = 0; mWr[d] = 0; mLast[d] = 1;
            mRv0[d] = 0; mRv1[d] = 0; mAddr[d] = 0; mWdata[d] = 0; mRd0[d] = 0; mRd1[d] = 0;
        end
    endtask

    task automatic model_eval(input int d, output logic [134:0] e, output bit g, output bit w);
        bit setup, access, arb;
        setup  = mBusy[d] && (cyc == mGrantCyc[d] + 1);
        access = mBusy[d] && (cyc == mGrantCyc[d] + 2);
        arb    = !mBusy[d] || access;
        g = arb && (req0_valid || req1_valid);
        if (d == 0) w = (req0_valid && req1_valid) ? !mLast[d] : req1_valid;
        else        w = !req0_valid;
        e = {g && !w, g && w, setup || access, access, mWr[d], mAddr[d], mWdata[d],
             mRv0[d], mRv1[d], mRd0[d], mRd1[d]};
    endtask

    task automatic model_advance(input int d, input bit g, input bit w);
        bit access;
        access = mBusy[d] && (cyc == mGrantCyc[d] + 2);
        mRv0[d] = 0; mRv1[d] = 0;
        if (access) begin
            if (!mOwner[d]) begin mRv0[d] = 1; mRd0[d] = mWr[d] ? 32'd0 : pReadData; end
            else            begin mRv1[d] = 1; mRd1[d] = mWr[d] ? 32'd0 : pReadData; end
            mBusy[d] = 0;
        end
        if (g) begin
            mBusy[d] = 1; mGrantCyc[d] = cyc; mOwner[d] = w; mLast[d] = w;
            mWr[d]    = w ? req1_write : req0_write;
            mAddr[d]  = w ? req1_addr  : req0_addr;
            mWdata[d] = w ? req1_wdata : req0_wdata;
        end
    endtask

    function automatic logic [134:0] observed(input int d);
        observed = {req0Ready[d], req1Ready[d], pSel[d], pEnable[d], pWrite[d], pAddr[d],
                    pWdata[d], req0Rvalid[d], req1Rvalid[d], req0Rdata[d], req1Rdata[d]};
    endfunction

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
    endtask

    // ---------------------------- tests ----------------------------
    task automatic test_reset();
        pReset = 0; req0_valid = 1; req1_valid = 1;
        repeat (3) begin
            @(negedge pClk); #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (observed(d) !== 135'd0) begin
                    fails++;
                    $display("FAIL reset_outputs dut%0d got=%h want=0", d, observed(d));
                end
            end
        end
        @(negedge pClk);
        idle_inputs(); pReset = 1; model_reset(); cyc = 0;
    endtask

    task automatic test_round_robin();
        logic [134:0] e; bit g [2]; bit w [2];
        for (int k = 0; k < 12; k++) begin
            @(negedge pClk);
            req0_valid = (k < 8); req0_write = 1; req0_addr = 32'd3; req0_wdata = 32'h00FFFF00;
            req1_valid = (k < 8); req1_write = 1; req1_addr = 32'd4; req1_wdata = 32'h00FFFF00;
            #1;
            for (int d = 0; d < 2; d++) begin
                model_eval(d, e, g[d], w[d]);
                checks++;
                if (observed(d) !== e) begin
                    fails++;
                    $display("FAIL rr_bus dut%0d cyc=%0d got=%h want=%h", d, cyc, observed(d), e);
                end
            end
            if (k < 8) begin
                checks++;
                if ({req0Ready[0], req1Ready[0]} !== {k % 4 == 0, k % 4 == 2}) begin
                    fails++;
                    $display("FAIL rr_alternate k=%0d got=%b want=%b", k,
                             {req0Ready[0], req1Ready[0]}, {k % 4 == 0, k % 4 == 2});
                end
            end
            @(posedge pClk);
            for (int d = 0; d < 2; d++) model_advance(d, g[d], w[d]);
            cyc++;
        end
    endtask

    task automatic test_single_write_read();
        logic [134:0] e; bit g [2]; bit w [2];
        for (int k = 0; k < 9; k++) begin
            @(negedge pClk);
            req0_valid = (k == 0); req0_write = 1; req0_addr = 32'd0; req0_wdata = 32'd10;
            req1_valid = (k == 3); req1_write = 0; req1_addr = 32'd1; req1_wdata = $urandom;
            pReadData = 32'd20;
            #1;
            for (int d = 0; d < 2; d++) begin
                model_eval(d, e, g[d], w[d]);
                checks++;
                if (observed(d) !== e) begin
                    fails++;
                    $display("FAIL single_bus dut%0d cyc=%0d got=%h want=%h", d, cyc, observed(d), e);
                end
            end
            if (k == 1) begin
                checks++;
                if ({pSel[0], pEnable[0], pWrite[0], pAddr[0], pWdata[0]} !== {3'b101, 32'd0, 32'd10}) begin
                    fails++;
                    $display("FAIL write_setup got=%h want=%h",
                             {pSel[0], pEnable[0], pWrite[0], pAddr[0], pWdata[0]}, {3'b101, 32'd0, 32'd10});
                end
            end
            if (k == 6) begin
                checks++;
                if ({req1Rvalid[0], req1Rdata[0], req0Rvalid[0]} !== {1'b1, 32'd20, 1'b0}) begin
                    fails++;
                    $display("FAIL read_complete got=%h want=%h",
                             {req1Rvalid[0], req1Rdata[0], req0Rvalid[0]}, {1'b1, 32'd20, 1'b0});
                end
            end
            @(posedge pClk);
            for (int d = 0; d < 2; d++) model_advance(d, g[d], w[d]);
            cyc++;
        end
    endtask

    task automatic test_fixed_priority();
        logic [134:0] e; bit g [2]; bit w [2];
        for (int k = 0; k < 12; k++) begin
            @(negedge pClk);
            req0_valid = (k < 6); req0_write = $urandom; req0_addr = $urandom; req0_wdata = $urandom;
            req1_valid = (k < 7); req1_write = $urandom; req1_addr = $urandom; req1_wdata = $urandom;
            pReadData = $urandom;
            #1;
            for (int d = 0; d < 2; d++) begin
                model_eval(d, e, g[d], w[d]);
                checks++;
                if (observed(d) !== e) begin
                    fails++;
                    $display("FAIL fp_bus dut%0d cyc=%0d got=%h want=%h", d, cyc, observed(d), e);
                end
            end
            if (k < 8) begin
                checks++;
                if ({req0Ready[1], req1Ready[1]} !== {k < 6 && k % 2 == 0, k == 6}) begin
                    fails++;
                    $display("FAIL fp_priority k=%0d got=%b want=%b", k,
                             {req0Ready[1], req1Ready[1]}, {k < 6 && k % 2 == 0, k == 6});
                end
            end
            @(posedge pClk);
            for (int d = 0; d < 2; d++) model_advance(d, g[d], w[d]);
            cyc++;
        end
    endtask

    task automatic test_random();
        logic [134:0] e; bit g [2]; bit w [2];
        for (int k = 0; k < 204; k++) begin
            @(negedge pClk);
            req0_valid = (k < 200) && $urandom_range(0, 2) != 0;
            req1_valid = (k < 200) && $urandom_range(0, 2) != 0;
            req0_write = $urandom; req0_addr = $urandom; req0_wdata = $urandom;
            req1_write = $urandom; req1_addr = $urandom; req1_wdata = $urandom;
            pReadData  = $urandom;
            #1;
            for (int d = 0; d < 2; d++) begin
                model_eval(d, e, g[d], w[d]);
                checks++;
                if (observed(d) !== e) begin
                    fails++;
                    $display("FAIL random_bus dut%0d cyc=%0d got=%h want=%h", d, cyc, observed(d), e);
                end
            end
            @(posedge pClk);
            for (int d = 0; d < 2; d++) model_advance(d, g[d], w[d]);
            cyc++;
        end
    endtask

    task automatic test_reset_midflight();
        logic [134:0] e; bit g [2]; bit w [2];
        // Grant a requester 0 write, then reset in the middle of its SETUP cycle.
        for (int k = 0; k < 2; k++) begin
            @(negedge pClk);
            req0_valid = (k == 0); req0_write = 1; req0_addr = 32'h55; req0_wdata = 32'hA5A5;
            req1_valid = 0;
            #1;
            for (int d = 0; d < 2; d++) begin
                model_eval(d, e, g[d], w[d]);
                checks++;
                if (observed(d) !== e) begin
                    fails++;
                    $display("FAIL pre_reset_bus dut%0d cyc=%0d got=%h want=%h", d, cyc, observed(d), e);
                end
            end
            if (k == 1) break;
            @(posedge pClk);
            for (int d = 0; d < 2; d++) model_advance(d, g[d], w[d]);
            cyc++;
        end
        #1 pReset = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({pSel[d], pEnable[d], req0Rvalid[d]} !== 3'b000) begin
                fails++;
                $display("FAIL async_reset dut%0d got=%b want=000", d, {pSel[d], pEnable[d], req0Rvalid[d]});
            end
        end
        model_reset();
        @(negedge pClk);
        pReset = 1; cyc = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge pClk);
            req0_valid = (k < 6); req0_write = 0; req0_addr = $urandom; req0_wdata = $urandom;
            req1_valid = (k < 6); req1_write = 0; req1_addr = $urandom; req1_wdata = $urandom;
            pReadData = $urandom;
            #1;
            for (int d = 0; d < 2; d++) begin
                model_eval(d, e, g[d], w[d]);
                checks++;
                if (observed(d) !== e) begin
                    fails++;
                    $display("FAIL post_reset_bus dut%0d cyc=%0d got=%h want=%h", d, cyc, observed(d), e);
                end
            end
            if (k == 0) begin
                checks++;
                if ({req0Ready[0], req1Ready[0]} !== 2'b10) begin
                    fails++;
                    $display("FAIL post_reset_tie got=%b want=10", {req0Ready[0], req1Ready[0]});
                end
            end
            @(posedge pClk);
            for (int d = 0; d < 2; d++) model_advance(d, g[d], w[d]);
            cyc++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_single_write_read();
        test_fixed_priority();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
